temp_buffer: RTL and testbench
==============================

Name: temp_buffer

Overview:
- Temporary data store for the CNN datapath: one row FIFO and one column FIFO sharing a single registered output.
- Each FIFO is loaded from the packet data word (WR_DATA) or by recirculating its own output (WR_BUF), so a convolution window can reuse values.
- Controlled by one TEMP_BUF_PACKET per cycle from the CNN controller. The read result feeds the PE array.

Parameters:
- XLEN, default `CNN_XLEN (16): data word width, signed two's complement.
- ROW_DEPTH, default 16: row FIFO entries; power of two.
- COL_DEPTH, default 16: column FIFO entries; power of two.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- temp_pk  input  TEMP_BUF_PACKET  per-cycle command, with these fields:
  - clean (1): clear both FIFOs.
  - stride (1): 1 = unit stride; 0 = stride 2.
  - wr_r / wr_c (enum): row / column write mode; NO_WR, WR_DATA or WR_BUF.
  - rd_r / rd_c (1): row / column read.
  - data_wr (XLEN): write data.
- data_out  output  XLEN signed  registered read result.

Behaviour:
- Reset (reset=0 at a rising edge):
  - both FIFOs empty; read/write pointers and counts = 0.
  - data_out = 0.
  - reset overrides every packet field.
- clean=1 (while reset=1): same effect as reset; all other fields are ignored that cycle.
- Each FIFO keeps rd_ptr, wr_ptr and count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - Storage needs no reset.
- Read arbitration:
  - rd_r and rd_c both 1: the row read wins; the column FIFO neither pops nor drives data_out.
  - Column WR_BUF requires its own read that cycle.
- Read, 1-cycle latency: on the edge, data_out <= head of the selected FIFO.
  - stride=1: pop 1 entry.
  - stride=0: pop 2 entries (the second is discarded); pop 1 if count=1.
- Read of an empty FIFO: data_out <= 0; pointers and count unchanged.
- No read this cycle: data_out holds its value.
- Write mode WR_DATA: push data_wr.
- Write mode WR_BUF:
  - push the value this FIFO returns this cycle (recirculation), only if this FIFO performs a non-empty read the same cycle.
  - otherwise the write is ignored.
- Write mode NO_WR: no push.
- Full FIFO (count=DEPTH):
  - a write is ignored unless the same FIFO pops in the same cycle.
  - with a simultaneous pop, the push succeeds.
- Simultaneous read and write on one FIFO:
  - the read uses the pre-edge head; count += 1 − pops.
  - write to an empty FIFO plus read: returns 0 (the new data is not bypassed); the data is stored.
- Row and column FIFOs are fully independent apart from the shared data_out and the arbitration rule.
- No X propagation: data_out is always a defined value after reset.

Test Plan:
1. Reset, then write 972 to both FIFOs (WR_DATA), rd_r twice, then rd_c twice -> data_out 972, 0, 972, 0.
2. Fill and drain:
   - WR_DATA 1..7 to both FIFOs; then rd_r with wr_c=WR_DATA carrying 8,9,10; then 4 more rd_r.
   - -> row reads 1..7, then 0 on the 8th read.
   - -> column holds 1..10 (count 10).
3. Column recirculation:
   - from scenario 2, 9 cycles of rd_c with wr_c=WR_BUF, then 7 cycles of rd_c only.
   - -> 1..9, then 10,1,2,3,4,5,6.
   - -> the column finishes holding 7,8,9 (count 3).
4. Stride 2: write 1..6 to row, stride=0, 3 reads -> 1,3,5, then 0; count 0.
5. Full and arbitration:
   - write 17 values with ROW_DEPTH=16 -> the 17th is dropped.
   - rd_r and rd_c together -> row head returned; column count unchanged.
6. clean and reset mid-operation:
   - clean=1 with data present -> data_out=0, next reads return 0.
   - reset=0 during writes -> the same result.

Source files
------------

// File: rtl/temp_buffer.sv
// Row/column scratch FIFOs for the CNN datapath with one shared registered read port.
// Either FIFO can be refilled from the packet word or by recirculating its own head.

`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package temp_buffer_pkg;

    typedef enum logic [1:0] {
        NO_WR   = 2'd0,
        WR_DATA = 2'd1,
        WR_BUF  = 2'd2
    } wr_mode_t;

    typedef struct packed {
        logic                   clean;
        logic                   stride;
        wr_mode_t               wr_r;
        wr_mode_t               wr_c;
        logic                   rd_r;
        logic                   rd_c;
        logic [`CNN_XLEN-1:0]   data_wr;
    } TEMP_BUF_PACKET;

endpackage

module temp_buffer
    import temp_buffer_pkg::*;
#(
    parameter int unsigned XLEN      = `CNN_XLEN,
    parameter int unsigned ROW_DEPTH = 16,
    parameter int unsigned COL_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  TEMP_BUF_PACKET         temp_pk,
    output logic signed [XLEN-1:0] data_out
);

    localparam int unsigned RAW = $clog2(ROW_DEPTH);
    localparam int unsigned CAW = $clog2(COL_DEPTH);

    logic [XLEN-1:0] row_mem [ROW_DEPTH];
    logic [XLEN-1:0] col_mem [COL_DEPTH];

    logic [RAW-1:0] row_rd_ptr_q, row_rd_ptr_d, row_wr_ptr_q, row_wr_ptr_d;
    logic [RAW:0]   row_count_q, row_count_d, row_pops;
    logic [CAW-1:0] col_rd_ptr_q, col_rd_ptr_d, col_wr_ptr_q, col_wr_ptr_d;
    logic [CAW:0]   col_count_q, col_count_d, col_pops;

    logic                   live, row_rd, col_rd;
    logic                   row_empty, row_full, row_push;
    logic                   col_empty, col_full, col_push;
    logic [XLEN-1:0]        wr_data, row_head, col_head, row_push_val, col_push_val;
    logic signed [XLEN-1:0] data_d;

    always_comb begin
        live     = reset && !temp_pk.clean;
        wr_data  = XLEN'(temp_pk.data_wr);
        // Row read has priority; the column only reads when the row does not.
        row_rd   = live && temp_pk.rd_r;
        col_rd   = live && temp_pk.rd_c && !temp_pk.rd_r;

        row_head  = row_mem[row_rd_ptr_q];
        row_empty = (row_count_q == '0);
        row_full  = (row_count_q == (RAW+1)'(ROW_DEPTH));
        col_head  = col_mem[col_rd_ptr_q];
        col_empty = (col_count_q == '0);
        col_full  = (col_count_q == (CAW+1)'(COL_DEPTH));

        row_pops = '0;
        if (row_rd && !row_empty) begin
            row_pops = (temp_pk.stride || row_count_q == (RAW+1)'(1)) ? (RAW+1)'(1)
                                                                       : (RAW+1)'(2);
        end
        col_pops = '0;
        if (col_rd && !col_empty) begin
            col_pops = (temp_pk.stride || col_count_q == (CAW+1)'(1)) ? (CAW+1)'(1)
                                                                       : (CAW+1)'(2);
        end

        // Recirculation only happens when this FIFO actually returned a stored value.
        row_push = live && (temp_pk.wr_r == WR_DATA ||
                            (temp_pk.wr_r == WR_BUF && row_pops != '0)) &&
                   (!row_full || row_pops != '0);
        col_push = live && (temp_pk.wr_c == WR_DATA ||
                            (temp_pk.wr_c == WR_BUF && col_pops != '0)) &&
                   (!col_full || col_pops != '0);

        row_push_val = (temp_pk.wr_r == WR_BUF) ? row_head : wr_data;
        col_push_val = (temp_pk.wr_c == WR_BUF) ? col_head : wr_data;

        row_count_d  = row_count_q - row_pops + {{RAW{1'b0}}, row_push};
        col_count_d  = col_count_q - col_pops + {{CAW{1'b0}}, col_push};
        row_rd_ptr_d = row_rd_ptr_q + RAW'(row_pops);
        col_rd_ptr_d = col_rd_ptr_q + CAW'(col_pops);
        row_wr_ptr_d = row_wr_ptr_q + {{(RAW-1){1'b0}}, row_push};
        col_wr_ptr_d = col_wr_ptr_q + {{(CAW-1){1'b0}}, col_push};

        data_d = data_out;
        if (row_rd) begin
            data_d = row_empty ? '0 : $signed(row_head);
        end else if (col_rd) begin
            data_d = col_empty ? '0 : $signed(col_head);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || temp_pk.clean) begin
            row_rd_ptr_q <= '0;
            row_wr_ptr_q <= '0;
            row_count_q  <= '0;
            col_rd_ptr_q <= '0;
            col_wr_ptr_q <= '0;
            col_count_q  <= '0;
            data_out     <= '0;
        end else begin
            row_rd_ptr_q <= row_rd_ptr_d;
            row_wr_ptr_q <= row_wr_ptr_d;
            row_count_q  <= row_count_d;
            col_rd_ptr_q <= col_rd_ptr_d;
            col_wr_ptr_q <= col_wr_ptr_d;
            col_count_q  <= col_count_d;
            data_out     <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (row_push) begin
            row_mem[row_wr_ptr_q] <= row_push_val;
        end
        if (col_push) begin
            col_mem[col_wr_ptr_q] <= col_push_val;
        end
    end

endmodule

// File: tb/tb_temp_buffer.sv
// Directed and random stimulus for temp_buffer, checked against a queue-based model.

module tb_temp_buffer;
    import temp_buffer_pkg::*;

    localparam int RD = 16;
    localparam int CD = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    TEMP_BUF_PACKET        temp_pk;
    logic signed [15:0]    data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]        rq[$];
    logic [15:0]        cq[$];
    logic signed [15:0] exp_out;
    string              tag;

    temp_buffer #(.XLEN(16), .ROW_DEPTH(RD), .COL_DEPTH(CD)) dut (
        .clk      (clk),
        .reset    (reset),
        .temp_pk  (temp_pk),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic cl, input logic st,
                        input wr_mode_t wr, input wr_mode_t wc,
                        input logic rr, input logic rc, input logic [15:0] d);
        int          rpre, cpre, rpop, cpop;
        logic [15:0] rret, cret, junk;
        reset   = rst;
        temp_pk = '{clean: cl, stride: st, wr_r: wr, wr_c: wc, rd_r: rr, rd_c: rc, data_wr: d};
        rpop = 0;
        cpop = 0;
        rret = '0;
        cret = '0;
        if (!rst || cl) begin
            rq.delete();
            cq.delete();
            exp_out = '0;
        end else begin
            rpre = rq.size();
            cpre = cq.size();
            if (rr) begin
                exp_out = '0;
                if (rpre > 0) begin
                    rret = rq.pop_front();
                    rpop = 1;
                    exp_out = rret;
                    if (!st && rq.size() > 0) begin
                        junk = rq.pop_front();
                        rpop = 2;
                    end
                end
            end else if (rc) begin
                exp_out = '0;
                if (cpre > 0) begin
                    cret = cq.pop_front();
                    cpop = 1;
                    exp_out = cret;
                    if (!st && cq.size() > 0) begin
                        junk = cq.pop_front();
                        cpop = 2;
                    end
                end
            end
            if (wr == WR_DATA && (rpre < RD || rpop > 0)) rq.push_back(d);
            else if (wr == WR_BUF && rpop > 0) rq.push_back(rret);
            if (wc == WR_DATA && (cpre < CD || cpop > 0)) cq.push_back(d);
            else if (wc == WR_BUF && cpop > 0) cq.push_back(cret);
        end
        @(posedge clk);
        #1;
        n_checks++;
        assert (data_out === exp_out) else begin
            n_fail++;
            $error("FAIL %s data_out: got %0d expected %0d", tag, data_out, exp_out);
        end
        n_checks++;
        assert (int'(dut.row_count_q) === rq.size()) else begin
            n_fail++;
            $error("FAIL %s row_count: got %0d expected %0d", tag, dut.row_count_q, rq.size());
        end
        n_checks++;
        assert (int'(dut.col_count_q) === cq.size()) else begin
            n_fail++;
            $error("FAIL %s col_count: got %0d expected %0d", tag, dut.col_count_q, cq.size());
        end
    endtask

    // Fixed values taken straight from the scenario descriptions.
    task automatic want(input string t, input int v);
        n_checks++;
        assert (int'(data_out) === v) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", t, data_out, v);
        end
    endtask

    task automatic idle();
        step(1, 0, 1, NO_WR, NO_WR, 0, 0, 16'd0);
    endtask

    initial begin
        tag = "reset";
        step(0, 0, 1, NO_WR, NO_WR, 0, 0, 16'd0);
        step(0, 0, 1, WR_DATA, WR_DATA, 1, 1, 16'd5);
        want("reset_out", 0);

        tag = "s1";
        step(1, 0, 1, WR_DATA, WR_DATA, 0, 0, 16'd972);
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s1_r0", 972);
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s1_r1", 0);
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s1_c0", 972);
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s1_c1", 0);

        tag = "s2";
        for (int i = 1; i <= 7; i++) step(1, 0, 1, WR_DATA, WR_DATA, 0, 0, 16'(i));
        for (int i = 8; i <= 10; i++) begin
            step(1, 0, 1, NO_WR, WR_DATA, 1, 0, 16'(i));
            want("s2_row", i - 7);
        end
        for (int i = 4; i <= 7; i++) begin
            step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);
            want("s2_row", i);
        end
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s2_row_empty", 0);

        tag = "s3";
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 1, NO_WR, WR_BUF, 0, 1, 16'd0);
            want("s3_recirc", i);
        end
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);
            want("s3_drain", (i == 0) ? 10 : i);
        end
        n_checks++;
        assert (int'(dut.col_count_q) === 3) else begin
            n_fail++;
            $error("FAIL s3_col_left: got %0d expected 3", dut.col_count_q);
        end

        tag = "s4";
        step(1, 1, 1, NO_WR, NO_WR, 0, 0, 16'd0);
        for (int i = 1; i <= 6; i++) step(1, 0, 1, WR_DATA, NO_WR, 0, 0, 16'(i));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, NO_WR, NO_WR, 1, 0, 16'd0);
            want("s4_stride2", 2 * i + 1);
        end
        step(1, 0, 0, NO_WR, NO_WR, 1, 0, 16'd0);  want("s4_empty", 0);

        tag = "s5";
        for (int i = 1; i <= 17; i++) step(1, 0, 1, WR_DATA, NO_WR, 0, 0, 16'(100 + i));
        step(1, 0, 1, NO_WR, WR_DATA, 0, 0, 16'd55);
        step(1, 0, 1, NO_WR, WR_BUF, 1, 1, 16'd0);  want("s5_arb", 101);
        for (int i = 2; i <= 16; i++) step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);
        want("s5_last", 116);
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s5_dropped", 0);
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s5_col", 55);

        tag = "s6";
        for (int i = 0; i < 4; i++) step(1, 0, 1, WR_DATA, WR_DATA, 0, 0, 16'(200 + i));
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s6_pre", 200);
        step(1, 1, 1, WR_DATA, WR_DATA, 1, 1, 16'd9);  want("s6_clean", 0);
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s6_row_after", 0);
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s6_col_after", 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, WR_DATA, WR_DATA, 0, 0, 16'(300 + i));
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s6_pre2", 300);
        step(0, 0, 1, WR_DATA, WR_DATA, 0, 0, 16'd7);  want("s6_reset", 0);
        step(1, 0, 1, NO_WR, NO_WR, 1, 0, 16'd0);  want("s6_rst_row", 0);
        step(1, 0, 1, NO_WR, NO_WR, 0, 1, 16'd0);  want("s6_rst_col", 0);

        tag = "rand";
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)),
                 wr_mode_t'($urandom_range(0, 2)), wr_mode_t'($urandom_range(0, 2)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
